// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, edit/view codes and digit index type for the display scanner.
package seg_pkg;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_MIN  = 2'd1;
  localparam logic [1:0] EDIT_HOUR = 2'd2;
  localparam logic VIEW_HHMM = 1'b0;
  localparam logic VIEW_MMSS = 1'b1;
  typedef logic [1:0] dig_idx_t;
endpackage

// File: rtl/seg_display_scanner_decoder.sv
// seg_decoder: combinational BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: 4-digit common-anode multiplexer with view select, edit blink and colon flash.
// Optional SEG_LZ_BLANK_EN blanks a leading zero on the leftmost digit.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       view_sel,
  input  logic [1:0] edit_pos,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  dig_idx_t      dig_idx_q, dig_idx_d;
  logic          blink_on_q, blink_on_d;
  logic [1:0]    edit_prev_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          scan_wrap, blink_wrap, edit_chg;
  logic [15:0]   digs;
  logic [3:0]    digit;
  logic          in_min, in_hour, blink_blank, lz_blank;
  seg_decoder u_dec (.bcd_i(digit), .seg_o(seg_d));
`ifdef SEG_LZ_BLANK_EN
  assign lz_blank = dig_idx_q == 2'd3 && digit == 4'd0;
`else
  assign lz_blank = 1'b0;
`endif
  always_comb begin
    scan_wrap   = scan_cnt_q == SCAN_MAX;
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    dig_idx_d   = scan_wrap ? dig_idx_q + 2'd1 : dig_idx_q;
    blink_wrap  = blink_cnt_q == BLINK_MAX;
    edit_chg    = edit_pos != edit_prev_q;
    blink_cnt_d = (edit_chg || blink_wrap) ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = edit_chg ? 1'b1 : blink_wrap ? ~blink_on_q : blink_on_q;
    digs        = view_sel == VIEW_MMSS ? {m2, m1, s2, s1} : {h2, h1, m2, m1};
    digit       = digs[{dig_idx_q, 2'b00} +: 4];
    // Minutes sit on the right pair in HH:MM and the left pair in MM:SS; hours only show in HH:MM.
    in_min      = view_sel == VIEW_HHMM ? ~dig_idx_q[1] : dig_idx_q[1];
    in_hour     = view_sel == VIEW_HHMM && dig_idx_q[1];
    blink_blank = ~blink_on_q && ((edit_pos == EDIT_MIN && in_min) || (edit_pos == EDIT_HOUR && in_hour));
    an_d        = (blink_blank || lz_blank) ? 4'b1111 : ~(4'b0001 << dig_idx_q);
    dp_d        = dig_idx_q == 2'd2 ? ~blink_on_q : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      edit_prev_q <= EDIT_NONE;
      an_q        <= 4'b1111;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      edit_prev_q <= edit_pos;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Drives the 4-digit, common-anode seven-segment display from the BCD time digits produced by the digital clock counter. Time-multiplexes one digit at a time, selects between the HH:MM and MM:SS views, blinks the field being edited, and flashes the colon decimal point. It is the stage directly downstream of the clock counter and the last stage before the board pins.

## Interface
- SCAN_DIV, 100_000: clock cycles per digit slot, giving a 1 kHz digit step at 100 MHz.
- BLINK_DIV, 50_000_000: clock cycles per blink half-period, giving a 1 Hz blink at 100 MHz.
- clk  in  1  system clock; all logic runs on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- h2, h1, m2, m1, s2, s1  in  4 each  BCD digits (tens/ones of hours, minutes, seconds), from the clock counter on the same clock.
- view_sel  in  1  0 = HH:MM view, 1 = MM:SS view.
- edit_pos  in  2  edit field: 0 = none, 1 = minutes, 2 = hours; 3 is treated as 0.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - scan_cnt = 0, dig_idx = 0.
  - blink_cnt = 0, blink_on = 1.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle, dig_idx advances 0→1→2→3→0.
- Digit mapping (dig_idx 3,2,1,0):
  - HH:MM view: h2, h1, m2, m1.
  - MM:SS view: m2, m1, s2, s1.
- Decode, seg = {g,f,e,d,c,b,a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values 10–15 give all segments off (1111111).
- Anode: an = ~(1 << dig_idx), unless the digit is blanked; a blanked digit gives an = 4'b1111.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; on wrap, blink_on toggles.
  - When blink_on = 0, the digits of the edited field are blanked, but only if that field is visible in the current view.
  - Minutes are digits 1,0 in HH:MM and digits 3,2 in MM:SS.
  - Hours are digits 3,2 in HH:MM and are not visible in MM:SS (no effect).
  - edit_pos = 0 or 3: no blanking.
- Edit restart: any change of edit_pos (compared with its registered previous value) clears blink_cnt and sets blink_on = 1. The newly selected field is therefore visible immediately. This takes priority over the wrap toggle in the same cycle.
- Colon: dp = ~blink_on when dig_idx = 2, otherwise dp = 1. The colon flashes whenever the display is on, independent of edit_pos.
- A view_sel change does not reset scan_cnt, dig_idx or blink state; the new mapping applies from the next output update.
- Inputs are used directly; they come from the same clock domain, so no synchronizer is required.

## Timing
- an, seg and dp are registered and recomputed every cycle from the current dig_idx, inputs and blink_on. Latency from an input change to the outputs is 1 cycle.
- dig_idx changes at edge N (the scan wrap); an/seg/dp show the new digit from edge N+1.
- A full refresh takes 4·SCAN_DIV cycles. The blink period is 2·BLINK_DIV cycles.
- Reset asserted mid-scan forces all reset values immediately (asynchronously). After release, the first non-blank output appears 1 cycle later, on digit 0.

## Configuration
- SEG_LZ_BLANK_EN:
  - Defined: the leftmost digit (dig_idx 3) is blanked (an = 4'b1111 for that slot) whenever its BCD value is 0. This applies to h2 in HH:MM and m2 in MM:SS, in addition to blink blanking.
  - Undefined: leading zeros are displayed normally.

## Structure
- Shared package seg_pkg holds:
  - the 7-bit segment constants SEG_0..SEG_9 and SEG_OFF;
  - the edit-position constants EDIT_NONE = 0, EDIT_MIN = 1, EDIT_HOUR = 2;
  - the view constants VIEW_HHMM = 0, VIEW_MMSS = 1;
  - a typedef for the 2-bit digit index.
- One sub-module, seg_decoder: combinational 4-bit BCD to 7-bit active-low segments, instantiated once.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_DIV = 16.
- Reset mapping: hold rst_n = 0 → an = 1111, seg = 1111111, dp = 1. Release with h2..m1 = 1,2,3,0 and view_sel = 0 → on successive slots, an = 1110 with seg = 1000000 ("0"), an = 1101 with "3", an = 1011 with "2" and dp = 0, an = 0111 with "1".
- View switch: s2,s1 = 5,9 with view_sel = 1 → slot 0 gives seg = 0010000 ("9"), slot 1 gives seg = 0010010 ("5"); slots 3,2 show m2, m1.
- Hour blink: view_sel = 0, edit_pos = 2 → slots 3,2 are dark (an = 1111) for 16 cycles out of every 32, and slots 1,0 are never dark. With view_sel = 1 and edit_pos = 2, no slot is ever dark.
- Edit restart: change edit_pos from 0 to 1 while blink_on = 0 → from the next cycle blink_on = 1, minute digits are visible, and the next toggle comes 16 cycles later.
- Invalid BCD: m1 = 4'hA → slot 0 gives seg = 1111111 while an = 1110.
- Leading zero: h2 = 0 in HH:MM → with SEG_LZ_BLANK_EN, slot 3 gives an = 1111; without it, slot 3 gives an = 0111 and seg = 1000000.
